bcd_pulse_gen: RTL and testbench
================================

Name: bcd_pulse_gen

Overview:
Takes a two-digit BCD count (00-99) and replays it as that many discrete pulses on a single serial line. This is the inverse of the team's BCD pulse counter, which turns pulses into q1:q0 digits. It is used to drive the counter from a known BCD value and close the loop in board-level self-test. A start/busy/done handshake controls it, and it reports the remaining count live in BCD.

Parameters:
PULSE_HIGH, 1, cycles the output is held high per pulse (1..15)
PULSE_GAP, 1, cycles the output is held low between consecutive pulses (1..15)

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  request; sampled only in IDLE
d0  in  4  BCD units digit of requested count
d1  in  4  BCD tens digit of requested count
d  out  1  generated pulse train
rem0  out  4  remaining pulses, BCD units
rem1  out  4  remaining pulses, BCD tens
busy  out  1  high while a pulse train is in progress
done  out  1  one-cycle strobe when a train completes
err  out  1  one-cycle strobe when a request is rejected as non-BCD

Behaviour:
- All outputs are registered. When reset=0 the block asynchronously enters IDLE with d=0, rem0=0, rem1=0, busy=0, done=0, err=0.
- States: IDLE, HIGH, LOW, FIN. Sub-phase timing uses one 4-bit phase counter.
- IDLE, start=1, d0>9 or d1>9:
  - err=1 for one cycle.
  - State stays IDLE; rem0/rem1 are unchanged.
- IDLE, start=1, d1:d0 = 00: go to FIN. No pulse is produced.
- IDLE, start=1, valid and nonzero:
  - Load rem1:rem0 from d1:d0 and go to HIGH.
  - d=1 and busy=1 from the clock edge that samples start. The first pulse is visible in the cycle after start is seen.
- HIGH:
  - d=1 for exactly PULSE_HIGH cycles.
  - On the last HIGH cycle, decrement rem1:rem0 by one in BCD: rem0=0 becomes rem0=9 with rem1-1; otherwise rem0-1.
  - If the result is 00, go to FIN; otherwise go to LOW.
- LOW: d=0, busy=1, for exactly PULSE_GAP cycles, then go to HIGH.
- FIN:
  - done=1 and busy=0 for exactly one cycle, d=0, rem1:rem0=00, then return to IDLE.
  - A start asserted in FIN is ignored.
- Total train length for N pulses: N*PULSE_HIGH + (N-1)*PULSE_GAP cycles, measured from the first d=1 cycle to the last d=1 cycle inclusive.
- start is ignored in HIGH, LOW and FIN. A request is never queued.
- err and done never assert in the same cycle.
- rem1:rem0 always holds valid BCD and never wraps below 00.
- Reset asserted mid-train aborts immediately: d drops asynchronously and no done strobe is produced.
- Maximum request 99: 99 pulses, and rem passes 90 -> 89 correctly on the tens borrow.

Optional Feature:
Macro BCD_PULSE_GEN_ABORT_EN.
- When defined: an extra input port abort (1 bit).
  - abort=1 sampled in HIGH or LOW moves the block to FIN on the next edge: d=0, done=1 for one cycle.
  - rem1:rem0 freezes at the count not yet emitted; a pulse in progress counts as not emitted.
  - abort in IDLE or FIN has no effect.
  - abort takes priority over the normal HIGH->LOW/FIN transition in the same cycle.
- When not defined: no abort port exists and every accepted train runs to completion.

Test Plan:
- Reset, then start with d1=0, d0=3 (PULSE_HIGH=1, PULSE_GAP=1) -> d reads 1,0,1,0,1; rem goes 03->02->01->00; done is 1 for one cycle right after the last pulse; busy high for 5 cycles.
- Start with d1=1, d0=0 -> exactly 10 pulses on d; rem shows 10->09 borrow after the first pulse; done once.
- Start with d0=0xA -> err=1 for one cycle; d stays 0; busy stays 0; rem unchanged. Start with 00 -> done one cycle after start, zero pulses.
- Start with 99, PULSE_HIGH=2, PULSE_GAP=3 -> 99 pulses, each 2 cycles high with 3-cycle gaps; train spans 492 cycles; a second start pulsed mid-train is ignored.
- Reset driven low during the 5th pulse of a 20-pulse train -> d=0 and rem=00 immediately; no done strobe. After release, a fresh start of 02 produces 2 pulses.
- With BCD_PULSE_GEN_ABORT_EN: abort during the 4th pulse of a 07 train -> done for one cycle; rem frozen at 04; only 3 complete pulses seen.

Source files
------------

// File: rtl/bcd_pulse_gen.sv
// Replays a two-digit BCD count (00-99) as that many pulses on d, with start/busy/done handshake.
// Optional abort input is enabled by defining BCD_PULSE_GEN_ABORT_EN.
module bcd_pulse_gen #(
   parameter int unsigned PULSE_HIGH = 1,  // 1..15
   parameter int unsigned PULSE_GAP  = 1   // 1..15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
`ifdef BCD_PULSE_GEN_ABORT_EN
   input  logic       abort,
`endif
   input  logic [3:0] d0,
   input  logic [3:0] d1,
   output logic       d,
   output logic [3:0] rem0,
   output logic [3:0] rem1,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [1:0] {StIdle, StHigh, StLow, StFin} state_e;

   localparam logic [3:0] HighLast = 4'(PULSE_HIGH - 1);
   localparam logic [3:0] GapLast  = 4'(PULSE_GAP - 1);

   state_e     state_q, state_d;
   logic [3:0] phase_q, phase_d;
   logic [3:0] rem0_q, rem0_d;
   logic [3:0] rem1_q, rem1_d;
   logic       d_q, d_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       err_q, err_d;

   logic       req_bad;
   logic       req_zero;
   logic       rem_is_one;
   logic       abort_req;

`ifdef BCD_PULSE_GEN_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   assign req_bad    = (d0 > 4'd9) || (d1 > 4'd9);
   assign req_zero   = (d0 == 4'd0) && (d1 == 4'd0);
   assign rem_is_one = (rem1_q == 4'd0) && (rem0_q == 4'd1);

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      rem0_d  = rem0_q;
      rem1_d  = rem1_q;
      err_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (req_bad) begin
                  err_d = 1'b1;
               end else begin
                  rem0_d  = d0;
                  rem1_d  = d1;
                  phase_d = 4'd0;
                  state_d = req_zero ? StFin : StHigh;
               end
            end
         end
         StHigh: begin
            // An aborted pulse is not counted, so rem keeps the not-yet-emitted total.
            if (abort_req) begin
               state_d = StFin;
               phase_d = 4'd0;
            end else if (phase_q == HighLast) begin
               phase_d = 4'd0;
               if (rem0_q == 4'd0) begin
                  rem0_d = 4'd9;
                  rem1_d = rem1_q - 4'd1;
               end else begin
                  rem0_d = rem0_q - 4'd1;
               end
               state_d = rem_is_one ? StFin : StLow;
            end else begin
               phase_d = phase_q + 4'd1;
            end
         end
         StLow: begin
            if (abort_req) begin
               state_d = StFin;
               phase_d = 4'd0;
            end else if (phase_q == GapLast) begin
               phase_d = 4'd0;
               state_d = StHigh;
            end else begin
               phase_d = phase_q + 4'd1;
            end
         end
         StFin: begin
            state_d = StIdle;
            phase_d = 4'd0;
         end
         default: begin
            state_d = StIdle;
            phase_d = 4'd0;
         end
      endcase

      // Outputs are registered copies of the next state so they line up with it.
      d_d    = (state_d == StHigh);
      busy_d = (state_d == StHigh) || (state_d == StLow);
      done_d = (state_d == StFin);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         phase_q <= 4'd0;
         rem0_q  <= 4'd0;
         rem1_q  <= 4'd0;
         d_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         rem0_q  <= rem0_d;
         rem1_q  <= rem1_d;
         d_q     <= d_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign d    = d_q;
   assign rem0 = rem0_q;
   assign rem1 = rem1_q;
   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;

`ifndef SYNTHESIS
   a_done_err_excl : assert property (@(posedge clk) disable iff (!reset) !(done && err));
   a_rem_bcd       : assert property (@(posedge clk) disable iff (!reset)
                                      (rem0 <= 4'd9) && (rem1 <= 4'd9));
   a_done_idle     : assert property (@(posedge clk) disable iff (!reset) done |-> (!busy && !d));
   a_d_busy        : assert property (@(posedge clk) disable iff (!reset) d |-> busy);
`endif

endmodule

// File: tb/tb_bcd_pulse_gen.sv
// Scoreboard bench for bcd_pulse_gen: two instances (1/1 and 2/3 timing), directed requests.
module tb_bcd_pulse_gen;

   localparam int unsigned HA = 1;
   localparam int unsigned GA = 1;
   localparam int unsigned HB = 2;
   localparam int unsigned GB = 3;

   typedef struct {
      int         inst;
      bit         is_err;
      int         n;
      int         full;
      int         shrt;
      int         span;
      logic [7:0] rfin;
      int         issue;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start_a = 1'b0, start_b = 1'b0;
   logic [3:0] d0_a = '0, d1_a = '0, d0_b = '0, d1_b = '0;
   logic       d_a, busy_a, done_a, err_a, d_b, busy_b, done_b, err_b;
   logic [3:0] rem0_a, rem1_a, rem0_b, rem1_b;
`ifdef BCD_PULSE_GEN_ABORT_EN
   logic       abort_a = 1'b0, abort_b = 1'b0;
`endif

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   // Per-instance monitor state
   int   rises[2], full[2], shrt[2], hrun[2], grun[2], first_t[2], last_h[2], busy_n[2];
   logic d_prev[2], done_prev[2], err_prev[2];
   logic dw[2], busyw[2], donew[2], errw[2];
   logic [7:0] remw[2];
   int   hw[2] = '{HA, HB};
   int   gw[2] = '{GA, GB};

   always #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   bcd_pulse_gen #(.PULSE_HIGH(HA), .PULSE_GAP(GA)) dut_a (
      .clk(clk), .reset(reset), .start(start_a),
`ifdef BCD_PULSE_GEN_ABORT_EN
      .abort(abort_a),
`endif
      .d0(d0_a), .d1(d1_a), .d(d_a), .rem0(rem0_a), .rem1(rem1_a),
      .busy(busy_a), .done(done_a), .err(err_a)
   );

   bcd_pulse_gen #(.PULSE_HIGH(HB), .PULSE_GAP(GB)) dut_b (
      .clk(clk), .reset(reset), .start(start_b),
`ifdef BCD_PULSE_GEN_ABORT_EN
      .abort(abort_b),
`endif
      .d0(d0_b), .d1(d1_b), .d(d_b), .rem0(rem0_b), .rem1(rem1_b),
      .busy(busy_b), .done(done_b), .err(err_b)
   );

   assign dw[0] = d_a;       assign dw[1] = d_b;
   assign busyw[0] = busy_a; assign busyw[1] = busy_b;
   assign donew[0] = done_a; assign donew[1] = done_b;
   assign errw[0] = err_a;   assign errw[1] = err_b;
   assign remw[0] = {rem1_a, rem0_a};
   assign remw[1] = {rem1_b, rem0_b};

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] t, u;
      t = 4'(v / 10);
      u = 4'(v % 10);
      return {t, u};
   endfunction

   task automatic chk(input string name, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
                  name, act, act, want, want, cyc);
      end
   endtask

   task automatic clr(input int i);
      rises[i] = 0; full[i] = 0; shrt[i] = 0; hrun[i] = 0; grun[i] = 0;
      first_t[i] = 0; last_h[i] = 0; busy_n[i] = 0;
   endtask

   // Monitor: tracks pulse shapes and rem live, pops the scoreboard on done/err
   initial begin
      for (int i = 0; i < 2; i++) begin
         clr(i);
         d_prev[i] = 1'b0; done_prev[i] = 1'b0; err_prev[i] = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (!reset) begin
               clr(i);
            end else begin
               bit have;
               int n;
               have = exp_q.size() > 0 && exp_q[0].inst == i && !exp_q[0].is_err;
               n = have ? exp_q[0].n : 0;
               if (dw[i] && !d_prev[i]) begin
                  rises[i]++;
                  if (rises[i] == 1) first_t[i] = cyc;
                  else chk("gap_len", grun[i], gw[i]);
                  grun[i] = 0;
                  hrun[i] = 0;
                  if (have) chk("rem_in_pulse", int'(remw[i]), int'(to_bcd(n - rises[i] + 1)));
                  else chk("unexpected_pulse", 1, 0);
               end
               if (dw[i]) begin
                  hrun[i]++;
                  last_h[i] = cyc;
               end
               if (!dw[i] && d_prev[i]) begin
                  if (hrun[i] == hw[i]) full[i]++;
                  else shrt[i]++;
               end
               if (busyw[i] && !dw[i]) begin
                  grun[i]++;
                  if (have) chk("rem_in_gap", int'(remw[i]), int'(to_bcd(n - rises[i])));
               end
               if (busyw[i]) busy_n[i]++;
               if (donew[i] && errw[i]) chk("done_and_err", 1, 0);
               if ((donew[i] && done_prev[i]) || (errw[i] && err_prev[i]))
                  chk("strobe_one_cycle", 1, 0);
               if (donew[i] || errw[i]) begin
                  if (exp_q.size() == 0 || exp_q[0].inst != i) begin
                     chk("unexpected_event", 1, 0);
                  end else begin
                     exp_t e;
                     e = exp_q.pop_front();
                     chk("event_kind_err", int'(errw[i]), int'(e.is_err));
                     chk("full_pulses", full[i], e.full);
                     chk("short_pulses", shrt[i], e.shrt);
                     chk("rem_at_event", int'(remw[i]), int'(e.rfin));
                     chk("busy_cycles", busy_n[i], e.span);
                     if (rises[i] > 0) begin
                        chk("train_span", last_h[i] - first_t[i] + 1, e.span);
                        chk("first_pulse_latency", first_t[i], e.issue + 1);
                        chk("done_after_last", cyc, last_h[i] + 1);
                     end else begin
                        chk("event_latency", cyc, e.issue + 1);
                     end
                  end
                  clr(i);
               end
            end
            d_prev[i] = dw[i];
            done_prev[i] = donew[i];
            err_prev[i] = errw[i];
         end
      end
   end

   task automatic issue(input int inst, input logic [3:0] t, input logic [3:0] u, input bit is_err,
                        input int n, input int fp, input int sp, input int span,
                        input logic [7:0] rfin);
      exp_t e;
      @(posedge clk);
      #1;
      if (inst == 0) begin
         d1_a = t; d0_a = u; start_a = 1'b1;
      end else begin
         d1_b = t; d0_b = u; start_b = 1'b1;
      end
      e.inst = inst; e.is_err = is_err; e.n = n; e.full = fp; e.shrt = sp;
      e.span = span; e.rfin = rfin; e.issue = cyc;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int k = 0;
      while (exp_q.size() > 0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL %s timeout: %0d events pending, want 0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_d", int'(d_a), 0);
      chk("reset_rem", int'({rem1_a, rem0_a}), 0);
      chk("reset_busy", int'(busy_a), 0);
      chk("reset_done", int'(done_a), 0);
      chk("reset_err", int'(err_a), 0);
      chk("reset_d_b", int'(d_b), 0);
      chk("reset_busy_b", int'(busy_b), 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // 03 at 1/1: 1,0,1,0,1 then done
      issue(0, 4'd0, 4'd3, 1'b0, 3, 3, 0, 5, 8'h00);
      wait_idle(50, "t03");

      // 10: tens borrow after the first pulse
      issue(0, 4'd1, 4'd0, 1'b0, 10, 10, 0, 19, 8'h00);
      wait_idle(100, "t10");

      // Non-BCD request rejected, rem unchanged
      issue(0, 4'd0, 4'hA, 1'b1, 0, 0, 0, 0, 8'h00);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("err_req_d_low", int'(d_a), 0);
         chk("err_req_busy_low", int'(busy_a), 0);
      end
      wait_idle(20, "terr");
      issue(0, 4'hC, 4'd1, 1'b1, 0, 0, 0, 0, 8'h00);
      wait_idle(20, "terr_tens");

      // 00: done only, no pulses
      issue(0, 4'd0, 4'd0, 1'b0, 0, 0, 0, 0, 8'h00);
      wait_idle(20, "t00");

      // 99 at 2/3 with an ignored start mid-train
      issue(1, 4'd9, 4'd9, 1'b0, 99, 99, 0, 492, 8'h00);
      repeat (100) @(posedge clk);
      #1;
      d1_b = 4'd0; d0_b = 4'd5; start_b = 1'b1;
      @(posedge clk);
      #1;
      start_b = 1'b0;
      wait_idle(1000, "t99");

      // Reset during the 5th pulse of a 20 train
      issue(0, 4'd2, 4'd0, 1'b0, 20, 20, 0, 39, 8'h00);
      begin
         int k = 0;
         @(negedge clk);
         #1;
         while (rises[0] != 5 && k < 200) begin
            @(negedge clk);
            #1;
            k++;
         end
         chk("reach_5th_pulse", rises[0], 5);
      end
      #1 reset = 1'b0;
      #1;
      chk("abort_reset_d", int'(d_a), 0);
      chk("abort_reset_rem", int'({rem1_a, rem0_a}), 0);
      chk("abort_reset_busy", int'(busy_a), 0);
      void'(exp_q.pop_front());
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("no_done_in_reset", int'(done_a), 0);
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      issue(0, 4'd0, 4'd2, 1'b0, 2, 2, 0, 3, 8'h00);
      wait_idle(50, "t02_after_reset");

`ifdef BCD_PULSE_GEN_ABORT_EN
      // Abort in the first cycle of the 4th pulse of 07 at 2/3
      issue(1, 4'd0, 4'd7, 1'b0, 7, 3, 1, 16, 8'h04);
      begin
         int k = 0;
         @(negedge clk);
         #1;
         while (rises[1] != 4 && k < 200) begin
            @(negedge clk);
            #1;
            k++;
         end
         chk("reach_4th_pulse", rises[1], 4);
      end
      abort_b = 1'b1;
      @(negedge clk);
      #1 abort_b = 1'b0;
      wait_idle(50, "tabort");
`endif

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
